fp_addsub_normalize_round: RTL and testbench

- Consumer end of the FP add/sub execute stage. Takes the raw 25-bit aligned sum, the guard/round/sticky bits, the larger exponent and the sign, and produces a packed IEEE-754 single-precision result.
- Normalisation is iterative: one shift per cycle. Rounding is round-to-nearest-even.
- Valid/ready handshake on both sides; one operation in flight.

---
 rtl/fp_addsub_pkg.sv | 15 +
 rtl/fp_round_rne.sv | 50 +++++
 rtl/fp_addsub_normalize_round.sv | 145 ++++++++++++++
 tb/tb_fp_addsub_normalize_round.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the FP add/sub normalise-and-round stage.
package fp_addsub_pkg;
   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] frac;
   } result_t;
endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even of a normalised (or subnormal) mantissa.
// A carry out of the increment renormalises by one place and bumps the exponent.
module fp_round_rne #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [MAN_W:0]   m_i,
   input  logic             g_i,
   input  logic             r_i,
   input  logic             s_i,
   input  logic [EXP_W+1:0] e_i,
   output logic [MAN_W-1:0] frac_o,
   output logic [EXP_W-1:0] exp_o,
   output logic             overflow_o,
   output logic             inexact_o,
   output logic             zero_o
);
   import fp_addsub_pkg::*;

   localparam logic [EXP_W+1:0] E_ONE = (EXP_W+2)'(1);
   localparam logic [EXP_W+1:0] E_INF = (EXP_W+2)'(EXP_MAX);

   logic             round_up;
   logic [MAN_W+1:0] m_inc;
   logic [MAN_W:0]   m_n;
   logic [EXP_W+1:0] e_n;

   always_comb begin
      round_up = g_i & (r_i | s_i | m_i[0]);
      m_inc    = {1'b0, m_i} + (MAN_W+2)'(round_up);
      if (m_inc[MAN_W+1]) begin
         m_n = m_inc[MAN_W+1:1];
         e_n = e_i + E_ONE;
      end else begin
         m_n = m_inc[MAN_W:0];
         e_n = e_i;
      end
      inexact_o  = g_i | r_i | s_i;
      zero_o     = (m_i == '0) && !(g_i | r_i | s_i);
      overflow_o = 1'b0;
      frac_o     = m_n[MAN_W-1:0];
      // Without a hidden bit the value is subnormal and encodes with a zero exponent.
      exp_o      = m_n[MAN_W] ? e_n[EXP_W-1:0] : '0;
      if (e_n >= E_INF) begin
         overflow_o = 1'b1;
         exp_o      = '1;
         frac_o     = '0;
      end
   end
endmodule

// File: rtl/fp_addsub_normalize_round.sv
// Normalise (one shift per cycle) and RNE-round an FP add/sub sum into IEEE single.
// Latency k+2 cycles for k shifts; one op in flight, result held until out_ready.
module fp_addsub_normalize_round #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [MAN_W+1:0]       sum_i,
   input  logic [2:0]             grs_i,
   input  logic [EXP_W-1:0]       exp_i,
   input  logic                   sign_i,
   input  logic                   eff_sub_i,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result_o,
   output logic                   overflow_o,
   output logic                   inexact_o
);
   import fp_addsub_pkg::*;

   localparam logic [EXP_W+1:0] E_ONE = (EXP_W+2)'(1);

   state_t           state_q, state_d;
   logic [MAN_W+1:0] m_q, m_d;
   logic             g_q, g_d, r_q, r_d, s_q, s_d;
   logic [EXP_W+1:0] e_q, e_d;
   logic             sign_q, sign_d, eff_sub_q, eff_sub_d;
   logic             out_valid_q, out_valid_d;
   result_t          res_q, res_d;
   logic             overflow_q, overflow_d, inexact_q, inexact_d;

   logic [MAN_W-1:0] rnd_frac;
   logic [EXP_W-1:0] rnd_exp;
   logic             rnd_ovf, rnd_inex, rnd_zero;

   fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
      .m_i        (m_q[MAN_W:0]),
      .g_i        (g_q),
      .r_i        (r_q),
      .s_i        (s_q),
      .e_i        (e_q),
      .frac_o     (rnd_frac),
      .exp_o      (rnd_exp),
      .overflow_o (rnd_ovf),
      .inexact_o  (rnd_inex),
      .zero_o     (rnd_zero)
   );

   always_comb begin
      state_d     = state_q;
      m_d         = m_q;
      g_d         = g_q;
      r_d         = r_q;
      s_d         = s_q;
      e_d         = e_q;
      sign_d      = sign_q;
      eff_sub_d   = eff_sub_q;
      out_valid_d = out_valid_q;
      res_d       = res_q;
      overflow_d  = overflow_q;
      inexact_d   = inexact_q;
      case (state_q)
         IDLE: if (in_valid) begin
            m_d       = sum_i;
            {g_d, r_d, s_d} = grs_i;
            e_d       = {2'b00, exp_i};
            sign_d    = sign_i;
            eff_sub_d = eff_sub_i;
            state_d   = NORM;
         end
         NORM: begin
            if (m_q[MAN_W+1]) begin
               m_d = m_q >> 1;
               s_d = s_q | r_q;
               r_d = g_q;
               g_d = m_q[0];
               e_d = e_q + E_ONE;
            end else if ((m_q == '0) && !(g_q | r_q | s_q)) begin
               state_d = ROUND;
            end else if (m_q[MAN_W] || (e_q == E_ONE)) begin
               state_d = ROUND;
            end else begin
               m_d = {m_q[MAN_W:0], g_q};
               g_d = r_q;
               r_d = 1'b0;
               e_d = e_q - E_ONE;
            end
         end
         ROUND: begin
            // An exact-zero difference is +0; otherwise the execute-stage sign stands.
            res_d.sign  = rnd_zero ? (sign_q & ~eff_sub_q) : sign_q;
            res_d.exp   = rnd_exp;
            res_d.frac  = rnd_frac;
            overflow_d  = rnd_ovf;
            inexact_d   = rnd_inex;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         m_q         <= '0;
         g_q         <= 1'b0;
         r_q         <= 1'b0;
         s_q         <= 1'b0;
         e_q         <= '0;
         sign_q      <= 1'b0;
         eff_sub_q   <= 1'b0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         overflow_q  <= 1'b0;
         inexact_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         m_q         <= m_d;
         g_q         <= g_d;
         r_q         <= r_d;
         s_q         <= s_d;
         e_q         <= e_d;
         sign_q      <= sign_d;
         eff_sub_q   <= eff_sub_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         overflow_q  <= overflow_d;
         inexact_q   <= inexact_d;
      end
   end

   assign in_ready   = rst_n && (state_q == IDLE);
   assign out_valid  = out_valid_q;
   assign result_o   = res_q;
   assign overflow_o = overflow_q;
   assign inexact_o  = inexact_q;
endmodule

// File: tb/tb_fp_addsub_normalize_round.sv
// Directed bench for fp_addsub_normalize_round with a queue-based scoreboard.
module tb_fp_addsub_normalize_round;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] sum_i;
   logic [2:0]  grs_i;
   logic [7:0]  exp_i;
   logic        sign_i;
   logic        eff_sub_i;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result_o;
   logic        overflow_o;
   logic        inexact_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        inex;
      int          lat;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   fp_addsub_normalize_round dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sum_i      (sum_i),
      .grs_i      (grs_i),
      .exp_i      (exp_i),
      .sign_i     (sign_i),
      .eff_sub_i  (eff_sub_i),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result_o   (result_o),
      .overflow_o (overflow_o),
      .inexact_o  (inexact_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, want);
      end
   endtask

   // Drive one op, wait for its result, and leave out_ready as the caller set it.
   task automatic issue(input string tag, input logic [24:0] s, input logic [2:0] grs,
                        input logic [7:0] e, input logic sg, input logic sub,
                        input logic [31:0] res, input logic ovf, input logic inex, input int lat);
      exp_t x;
      exp_t y;
      int   cyc;
      x.res = res; x.ovf = ovf; x.inex = inex; x.lat = lat;
      sb.push_back(x);
      @(negedge clk);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      sum_i = s; grs_i = grs; exp_i = e; sign_i = sg; eff_sub_i = sub; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk);
         cyc++;
         #1;
      end while (!out_valid && cyc < 100);
      y = sb.pop_front();
      chk({tag, "_latency"}, 32'(cyc), 32'(y.lat));
      chk({tag, "_result"}, result_o, y.res);
      chk({tag, "_overflow"}, 32'(overflow_o), 32'(y.ovf));
      chk({tag, "_inexact"}, 32'(inexact_o), 32'(y.inex));
   endtask

   task automatic drain(input string tag);
      @(posedge clk);
      #1 chk({tag, "_released"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] held;
      int          seen;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      sum_i = '0; grs_i = '0; exp_i = '0; sign_i = 1'b0; eff_sub_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result_o, 32'h0);
      chk("rst_overflow", 32'(overflow_o), 32'd0);
      chk("rst_inexact", 32'(inexact_o), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      issue("carry",   25'h1000000, 3'b000, 8'd127, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 3);  drain("carry");
      issue("tie_odd", 25'h0800001, 3'b100, 8'd127, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b1, 2);  drain("tie_odd");
      issue("tie_even",25'h0800000, 3'b100, 8'd127, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b1, 2);  drain("tie_even");
      issue("sticky",  25'h0800000, 3'b101, 8'd127, 1'b0, 1'b0, 32'h3F800001, 1'b0, 1'b1, 2);  drain("sticky");
      issue("rnd_carry",25'h0FFFFFF,3'b110, 8'd127, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b1, 2);  drain("rnd_carry");
      issue("neg",     25'h0C00000, 3'b000, 8'd127, 1'b1, 1'b0, 32'hBFC00000, 1'b0, 1'b0, 2);  drain("neg");
      issue("carry_g", 25'h1000001, 3'b000, 8'd127, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b1, 3);  drain("carry_g");
      issue("cancel",  25'h0000001, 3'b000, 8'd127, 1'b0, 1'b1, 32'h34000000, 1'b0, 1'b0, 25); drain("cancel");
      issue("subnorm", 25'h0000001, 3'b000, 8'd5,   1'b0, 1'b1, 32'h00000010, 1'b0, 1'b0, 6);  drain("subnorm");
      issue("ovf",     25'h1000000, 3'b000, 8'd254, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 3);  drain("ovf");
      issue("zero_sub",25'h0000000, 3'b000, 8'd100, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0, 2);  drain("zero_sub");
      issue("zero_add",25'h0000000, 3'b000, 8'd100, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b0, 2);  drain("zero_add");

      // Backpressure: result must hold for 10 stalled cycles, then transfer exactly once.
      out_ready = 1'b0;
      issue("bp", 25'h0800001, 3'b100, 8'd127, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b1, 2);
      held = result_o;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_result", result_o, 32'h3F800002);
         chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      chk("bp_stable", result_o, held);
      @(negedge clk) out_ready = 1'b1;
      drain("bp");
      chk("bp_sb_empty", 32'(sb.size()), 32'd0);

      // Reset during a long normalisation must discard the operation.
      @(negedge clk);
      sum_i = 25'h0000001; grs_i = '0; exp_i = 8'd127; sign_i = 1'b0; eff_sub_i = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("mid_rst_idle", 32'(in_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1 if (out_valid) seen++;
      end
      chk("mid_rst_no_output", 32'(seen), 32'd0);
      issue("post_rst", 25'h1000000, 3'b000, 8'd127, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 3);
      drain("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
